// File: rtl/reset_run_sequencer.sv
// Reset/run sequencer: ADC reset, then core reset, then a timed RUN ending in PASS or FAIL.
// Optional build macro RESET_RUN_SEQUENCER_TRACE_EN adds a free-running trace_count output.
module reset_run_sequencer #(
    parameter int ADC_RST_CYC  = 8,
    parameter int CORE_RST_CYC = 16,
    parameter int CNT_W        = 64
) (
    input  logic             core_clock,
    input  logic             reset,
    input  logic             success,
    input  logic             fail_req,
    input  logic [CNT_W-1:0] max_cycles,
    output logic             adc_reset,
    output logic             core_reset,
    output logic             run_active,
    output logic             finish,
    output logic             failed,
    output logic [1:0]       fail_reason,
    output logic [CNT_W-1:0] cycle_count
`ifdef RESET_RUN_SEQUENCER_TRACE_EN
    ,
    output logic [CNT_W-1:0] trace_count
`endif
);

    localparam int PH_MAX = (ADC_RST_CYC > CORE_RST_CYC) ? ADC_RST_CYC : CORE_RST_CYC;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    localparam logic [2:0] ST_ADC_RST  = 3'd0;
    localparam logic [2:0] ST_CORE_RST = 3'd1;
    localparam logic [2:0] ST_RUN      = 3'd2;
    localparam logic [2:0] ST_PASS     = 3'd3;
    localparam logic [2:0] ST_FAIL     = 3'd4;

    logic [2:0]      state;
    logic [PH_W-1:0] phase;
    logic            timeout;

    // Compared against the count before this cycle's increment.
    assign timeout = (max_cycles != '0) && (cycle_count >= max_cycles);

    always_ff @(posedge core_clock) begin
        if (!reset) begin
            state       <= ST_ADC_RST;
            phase       <= '0;
            adc_reset   <= 1'b1;
            core_reset  <= 1'b1;
            run_active  <= 1'b0;
            finish      <= 1'b0;
            failed      <= 1'b0;
            fail_reason <= 2'b00;
            cycle_count <= '0;
        end else begin
            finish <= 1'b0;
            case (state)
                ST_ADC_RST: begin
                    if (phase == PH_W'(ADC_RST_CYC - 1)) begin
                        state     <= ST_CORE_RST;
                        phase     <= '0;
                        adc_reset <= 1'b0;
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                ST_CORE_RST: begin
                    if (phase == PH_W'(CORE_RST_CYC - 1)) begin
                        state      <= ST_RUN;
                        phase      <= '0;
                        core_reset <= 1'b0;
                        run_active <= 1'b1;
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                ST_RUN: begin
                    if (cycle_count != '1)
                        cycle_count <= cycle_count + CNT_W'(1);
                    // Failure causes outrank a simultaneous success.
                    if (timeout) begin
                        state       <= ST_FAIL;
                        run_active  <= 1'b0;
                        finish      <= 1'b1;
                        failed      <= 1'b1;
                        fail_reason <= 2'b01;
                    end else if (fail_req) begin
                        state       <= ST_FAIL;
                        run_active  <= 1'b0;
                        finish      <= 1'b1;
                        failed      <= 1'b1;
                        fail_reason <= 2'b10;
                    end else if (success) begin
                        state      <= ST_PASS;
                        run_active <= 1'b0;
                        finish     <= 1'b1;
                    end
                end
                ST_PASS, ST_FAIL: ;
                default: begin
                    state      <= ST_ADC_RST;
                    phase      <= '0;
                    adc_reset  <= 1'b1;
                    core_reset <= 1'b1;
                    run_active <= 1'b0;
                end
            endcase
        end
    end

`ifdef RESET_RUN_SEQUENCER_TRACE_EN
    always_ff @(posedge core_clock) begin
        if (!reset)
            trace_count <= '0;
        else if (trace_count != '1)
            trace_count <= trace_count + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_reset_run_sequencer.sv
// Bench for reset_run_sequencer: directed and randomized runs against a timeline model
// (cycles since release, run index, latched outcome).
module tb_reset_run_sequencer;

    localparam int ADC_CYC  = 8;
    localparam int CORE_CYC = 16;
    localparam int RUN_AT   = ADC_CYC + CORE_CYC;

    logic        core_clock = 1'b0;
    logic        reset      = 1'b0;
    logic        success    = 1'b0;
    logic        fail_req   = 1'b0;
    logic [63:0] max_cycles = '0;
    logic        adc_reset, core_reset, run_active, finish, failed;
    logic [1:0]  fail_reason;
    logic [63:0] cycle_count;
`ifdef RESET_RUN_SEQUENCER_TRACE_EN
    logic [63:0] trace_count;
`endif

    reset_run_sequencer dut (
        .core_clock (core_clock),
        .reset      (reset),
        .success    (success),
        .fail_req   (fail_req),
        .max_cycles (max_cycles),
        .adc_reset  (adc_reset),
        .core_reset (core_reset),
        .run_active (run_active),
        .finish     (finish),
        .failed     (failed),
        .fail_reason(fail_reason),
        .cycle_count(cycle_count)
`ifdef RESET_RUN_SEQUENCER_TRACE_EN
        ,
        .trace_count(trace_count)
`endif
    );

    always #5 core_clock = ~core_clock;

    int n_cmp = 0;
    int n_mis = 0;

    // Timeline model: m_t = edges since the last reset edge; outcome latched once decided.
    longint unsigned m_t;
    bit              m_done, m_fin, m_failed;
    logic [63:0]     m_cnt;
    logic [1:0]      m_reason;

    function automatic bit m_in_run();
        return (m_t >= RUN_AT) && !m_done;
    endfunction

    function automatic int run_idx();
        return int'(m_t) - RUN_AT + 1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
            $error("check %s differs", tag);
        end
    endtask

    task automatic check_all();
        chk("adc_reset",   64'(adc_reset),   64'(m_t < ADC_CYC));
        chk("core_reset",  64'(core_reset),  64'(m_t < RUN_AT));
        chk("run_active",  64'(run_active),  64'(m_in_run()));
        chk("finish",      64'(finish),      64'(m_fin));
        chk("failed",      64'(failed),      64'(m_failed));
        chk("fail_reason", 64'(fail_reason), 64'(m_reason));
        chk("cycle_count", cycle_count,      m_cnt);
`ifdef RESET_RUN_SEQUENCER_TRACE_EN
        chk("trace_count", trace_count,      64'(m_t));
`endif
    endtask

    task automatic step(input logic r, input logic s, input logic f);
        bit was_run;
        reset = r; success = s; fail_req = f;
        @(posedge core_clock);
        if (!r) begin
            m_t = 0; m_done = 0; m_fin = 0; m_failed = 0; m_cnt = '0; m_reason = 2'b00;
        end else begin
            was_run = m_in_run();
            m_fin = 0;
            if (was_run) begin
                if (max_cycles != 0 && m_cnt >= max_cycles) begin
                    m_done = 1; m_fin = 1; m_failed = 1; m_reason = 2'b01;
                end else if (f) begin
                    m_done = 1; m_fin = 1; m_failed = 1; m_reason = 2'b10;
                end else if (s) begin
                    m_done = 1; m_fin = 1;
                end
                if (m_cnt != '1) m_cnt = m_cnt + 1;
            end
            m_t++;
        end
        #1;
        check_all();
    endtask

    // One run: reset, then ncyc cycles; success/fail_req pulse at given RUN indices,
    // random noise outside RUN, optional reset pulse at RUN index rst_at.
    task automatic scenario(input logic [63:0] mx, input int succ_at, input int fail_at,
                            input int rst_at, input int ncyc);
        int ra;
        ra = rst_at;
        max_cycles = mx;
        step(1'b0, 1'($urandom), 1'($urandom));
        step(1'b0, 1'($urandom), 1'($urandom));
        for (int i = 0; i < ncyc; i++) begin
            if (m_in_run()) begin
                if (run_idx() == ra) begin
                    ra = -1;
                    step(1'b0, 1'b0, 1'b0);
                end else begin
                    step(1'b1, 1'(run_idx() == succ_at), 1'(run_idx() == fail_at));
                end
            end else begin
                step(1'b1, 1'($urandom), 1'($urandom));
            end
        end
    endtask

    initial begin
        // Reset state.
        step(1'b0, 1'b0, 1'b0);
        chk("rst_adc", 64'(adc_reset), 64'd1);
        chk("rst_cnt", cycle_count, 64'd0);

        // Timeout with no success.
        scenario(64'd100, -1, -1, -1, RUN_AT + 130);
        chk("to_reason", 64'(fail_reason), 64'd1);
        chk("to_count",  cycle_count,      64'd101);

        // Pass at RUN cycle 37, no timeout.
        scenario(64'd0, 37, -1, -1, RUN_AT + 60);
        chk("pass_failed", 64'(failed), 64'd0);
        chk("pass_count",  cycle_count, 64'd37);

        // Success coincides with timeout.
        scenario(64'd10, 11, -1, -1, RUN_AT + 20);
        chk("tie_to_reason", 64'(fail_reason), 64'd1);
        chk("tie_to_count",  cycle_count,      64'd11);

        // Success coincides with fail_req.
        scenario(64'd0, 5, 5, -1, RUN_AT + 15);
        chk("tie_fr_reason", 64'(fail_reason), 64'd2);
        chk("tie_fr_failed", 64'(failed),      64'd1);

        // Reset pulsed at RUN cycle 5, sequence restarts.
        scenario(64'd0, 20, -1, 5, 2 * RUN_AT + 40);
        chk("rerun_count", cycle_count, 64'd20);

        // Randomized runs.
        for (int k = 0; k < 20; k++) begin
            scenario(64'($urandom_range(0, 40)), int'($urandom_range(1, 50)),
                     int'($urandom_range(1, 60)),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : -1,
                     2 * RUN_AT + int'($urandom_range(10, 70)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/reset_run_sequencer.md
RESET_RUN_SEQUENCER -- requirements
Module: reset_run_sequencer

Interface
REQ-001 SHALL have parameter ADC_RST_CYC, default 8, core_clock cycles adc_reset stays high after reset release (>=1).
REQ-002 SHALL have parameter CORE_RST_CYC, default 16, core_clock cycles core_reset stays high after adc_reset falls (>=1).
REQ-003 SHALL have parameter CNT_W, default 64, width of run cycle counter and max_cycles.
REQ-004 SHALL have port core_clock  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port success  input  1  harness pass indication, sampled during RUN only.
REQ-007 SHALL have port fail_req  input  1  external failure request, sampled during RUN only.
REQ-008 SHALL have port max_cycles  input  CNT_W  run timeout; 0 disables timeout.
REQ-009 SHALL have port adc_reset  output  1  active-high ADC/DSP-clock-domain reset to harness.
REQ-010 SHALL have port core_reset  output  1  active-high core/serial reset to harness.
REQ-011 SHALL have port run_active  output  1  high while in RUN.
REQ-012 SHALL have port finish  output  1  one-cycle pulse on entry to PASS or FAIL.
REQ-013 SHALL have port failed  output  1  level, high in FAIL.
REQ-014 SHALL have port fail_reason  output  2  00 none, 01 timeout, 10 fail_req.
REQ-015 SHALL have port cycle_count  output  CNT_W  RUN cycles elapsed, frozen after finish.

Function
REQ-016 SHALL implement FSM states ADC_RST, CORE_RST, RUN, PASS, FAIL.
REQ-017 ADC_RST: adc_reset=1, core_reset=1; phase counter counts; after ADC_RST_CYC cycles in state SHALL go CORE_RST.
REQ-018 CORE_RST: adc_reset=0, core_reset=1; after CORE_RST_CYC cycles in state SHALL go RUN.
REQ-019 RUN: both resets 0, run_active=1; cycle_count SHALL increment by 1 each RUN cycle, starting at 1 on the first RUN cycle.
REQ-020 In RUN, timeout SHALL be true when max_cycles!=0 and cycle_count >= max_cycles (registered value, pre-increment).
REQ-021 Priority in RUN SHALL be: timeout (FAIL, reason 01) > fail_req (FAIL, reason 10) > success (PASS); failure wins over simultaneous success.
REQ-022 PASS and FAIL SHALL be terminal until reset; resets stay deasserted, cycle_count and fail_reason hold.
REQ-023 finish SHALL be high exactly the first cycle in PASS/FAIL; failed registered, valid same cycle as finish.
REQ-024 cycle_count SHALL saturate at all-ones, never wrap.
REQ-025 success/fail_req outside RUN SHALL be ignored.
REQ-026 All outputs SHALL be registered (no combinational input-to-output path).

Reset
REQ-027 With reset=0 at a rising edge: state=ADC_RST, phase counter=0, adc_reset=1, core_reset=1, run_active=0, finish=0, failed=0, fail_reason=00, cycle_count=0.
REQ-028 Reset asserted mid-RUN or in PASS/FAIL SHALL restart the full sequence from ADC_RST next edge.
REQ-029 Reset applied in any cycle SHALL reassert adc_reset and core_reset at the next edge.

Configuration
REQ-030 Macro RESET_RUN_SEQUENCER_TRACE_EN: when defined, SHALL add output trace_count (CNT_W), counting every core_clock cycle since reset release in all states, saturating; cleared by reset.
REQ-031 Without RESET_RUN_SEQUENCER_TRACE_EN, port trace_count and its counter SHALL not exist; all other behaviour identical.

Verification
REQ-032 Defaults, release reset at cycle 0 -> adc_reset falls after 8 cycles, core_reset falls 16 cycles later, run_active rises same edge.
REQ-033 max_cycles=100, success never -> FAIL, fail_reason=01, finish one pulse, cycle_count=101 frozen.
REQ-034 max_cycles=0, success at RUN cycle 37 -> PASS, failed=0, cycle_count=37, no later finish.
REQ-035 max_cycles=10, success and timeout same cycle; also fail_req with success -> failed=1, reason 01 and 10 respectively.
REQ-036 Reset pulsed at RUN cycle 5 -> all outputs to reset values, full 8+16 sequence repeats, cycle_count restarts at 1.
REQ-037 Build with RESET_RUN_SEQUENCER_TRACE_EN -> trace_count = 24 on first RUN cycle; without, port absent, REQ-032..036 pass unchanged.
